// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage and its instruction buffer.
package rv_fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_KILL,
    FETCH_HALT
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head; flush wins over push/pop,
// and push is accepted while full when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] slot_data [DEPTH];

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = slot_data[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0] entry_q;
      always_ff @(posedge clk) begin
        if (do_push && !flush && (wr_ptr_q == AW'(gi))) begin
          entry_q <= din;
        end
      end
      assign slot_data[gi] = entry_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, single-outstanding imem request FSM, redirect/kill
// handling and an instruction buffer feeding the decoder.
module instruction_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_en,
  output logic [31:0] dec_instruction_code,
  output logic [31:0] dec_pc,
  output logic        fetch_misaligned
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         kill_q, kill_d;
  logic         halt_pend_q, halt_pend_d;
  logic         misaligned_q, misaligned_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [FETCH_ENTRY_W-1:0] fifo_dout;

  logic [CW:0]  count_after;
  logic         has_space;
  logic         redirect_bad;
  fetch_state_e redirect_target;
  fetch_state_e kill_exit;
  logic [31:0]  req_addr;

  assign dec_en   = ~fifo_empty;
  assign fifo_pop = dec_en & dec_ready;
  assign fifo_push = (state_q == FETCH_WAIT) & imem_rvalid & ~redirect_valid;

  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = fetch_pc_q;
  assign head_entry      = fifo_dout;

  // Occupancy at the end of this cycle, so a same-cycle pop frees a slot for issue.
  assign count_after = {1'b0, fifo_count}
                     + {{CW{1'b0}}, fifo_push}
                     - {{CW{1'b0}}, fifo_pop};
  assign has_space   = count_after < (CW+1)'(FIFO_DEPTH);

  assign redirect_bad    = redirect_valid & is_misaligned(redirect_pc[1:0]);
  assign redirect_target = redirect_bad ? FETCH_HALT : FETCH_REQ;
  assign kill_exit       = redirect_valid ? redirect_target
                         : (halt_pend_q ? FETCH_HALT : FETCH_REQ);

  // A redirect during an ungranted request keeps the old address on the bus.
  assign req_addr  = kill_q ? fetch_pc_q : pc_q;
  assign imem_addr = req_addr & 32'hFFFF_FFFC;
  assign imem_req  = (state_q == FETCH_REQ);

  assign dec_instruction_code = dec_en ? head_entry.inst : 32'h0;
  assign dec_pc               = dec_en ? head_entry.pc   : 32'h0;
  assign fetch_misaligned     = misaligned_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    halt_pend_d  = halt_pend_q;
    misaligned_d = misaligned_q;

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      halt_pend_d = redirect_bad;
      if (redirect_bad) misaligned_d = 1'b1;
    end

    case (state_q)
      FETCH_IDLE: begin
        if (redirect_valid)  state_d = redirect_target;
        else if (has_space)  state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (imem_gnt) begin
          if (redirect_valid || kill_q) begin
            state_d = FETCH_KILL;
            kill_d  = 1'b0;
          end else begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH_WAIT;
          end
        end else if (redirect_valid) begin
          if (!kill_q) fetch_pc_d = pc_q;
          kill_d = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid)  state_d = redirect_target;
          else if (has_space)  state_d = FETCH_REQ;
          else                 state_d = FETCH_IDLE;
        end else if (redirect_valid) begin
          state_d = FETCH_KILL;
        end
      end
      FETCH_KILL: begin
        if (imem_rvalid) state_d = kill_exit;
      end
      FETCH_HALT: begin
        if (redirect_valid) state_d = redirect_target;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      kill_q       <= 1'b0;
      halt_pend_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      halt_pend_q  <= halt_pend_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small in-order memory responder.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_en;
  logic [31:0] dec_instruction_code;
  logic [31:0] dec_pc;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  int gnt_en  = 1;
  int mem_lat = 1;

  logic        gnt_prev  = 1'b0;
  logic        pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] addr_prev = 32'h0;

  int watch_pc4 = 0;
  int seen_pc4  = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_gnt             (imem_gnt),
    .imem_rvalid          (imem_rvalid),
    .imem_rdata           (imem_rdata),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .dec_ready            (dec_ready),
    .dec_en               (dec_en),
    .dec_instruction_code (dec_instruction_code),
    .dec_pc               (dec_pc),
    .fetch_misaligned     (fetch_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1300_0013);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end else begin
      $display("check %s: %08h ok", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect_pc    = tgt;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req_addr(input string tag, input logic [31:0] addr, input int max);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (imem_req && imem_addr == addr) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'b0, found}, 32'h1);
  endtask

  task automatic wait_dec(input string tag, input int max);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (dec_en) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'b0, found}, 32'h1);
  endtask

  // Memory: grant whenever enabled, answer in order mem_lat cycles after the grant.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (gnt_prev) begin
        pend      = 1'b1;
        pend_cnt  = mem_lat;
        pend_addr = addr_prev;
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end
      end
      gnt_prev  = imem_req && (gnt_en != 0);
      imem_gnt  = gnt_prev;
      addr_prev = imem_addr;
    end
  end

  always @(negedge clk) begin
    #1;
    if (watch_pc4 != 0 && dec_en && dec_pc == 32'h4) seen_pc4++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    int dec_cnt;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req",  {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_dec_en", {31'b0, dec_en}, 32'h0);
    check("rst_code", dec_instruction_code, 32'h0);
    check("rst_pc",   dec_pc, 32'h0);
    check("rst_mis",  {31'b0, fetch_misaligned}, 32'h0);

    // First fetch latency, then buffer fill with decoder stalled
    do_reset();
    tick();
    check("t1_req",  {31'b0, imem_req}, 32'h1);
    check("t1_addr", imem_addr, 32'h0);
    tick();
    tick();
    check("t1_dec_en", {31'b0, dec_en}, 32'h1);
    check("t1_code", dec_instruction_code, 32'h0050_0093);
    check("t1_pc",   dec_pc, 32'h0);
    check("t1_next_addr", imem_addr, 32'h4);
    repeat (5) tick();
    check("t2_req_off", {31'b0, imem_req}, 32'h0);
    check("t2_head_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    tick();
    check("t2_drain_pc",   dec_pc, 32'h4);
    check("t2_drain_code", dec_instruction_code, mem_word(32'h4));
    check("t2_resume_req", {31'b0, imem_req}, 32'h1);
    check("t2_resume_addr", imem_addr, 32'h8);
    tick();
    check("t2_empty", {31'b0, dec_en}, 32'h0);

    // Redirect while waiting on a slow response
    do_reset();
    mem_lat   = 3;
    watch_pc4 = 1;
    seen_pc4  = 0;
    tick();
    wait_req_addr("t3_req4", 32'h4, 20);
    tick();
    check("t3_in_wait", {31'b0, imem_req}, 32'h0);
    pulse_redirect(32'h100);
    wait_req_addr("t3_req100", 32'h100, 20);
    wait_dec("t3_dec", 20);
    check("t3_pc",   dec_pc, 32'h100);
    check("t3_code", dec_instruction_code, mem_word(32'h100));
    repeat (4) tick();
    watch_pc4 = 0;
    check("t3_no_pc4", seen_pc4, 0);

    // Redirect coinciding with rvalid while one entry is buffered
    do_reset();
    mem_lat   = 1;
    dec_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t4_buffered", {31'b0, dec_en}, 32'h1);
    tick();
    check("t4_wait", {31'b0, imem_req}, 32'h0);
    pulse_redirect(32'h200);
    check("t4_flushed", {31'b0, dec_en}, 32'h0);
    check("t4_req",  {31'b0, imem_req}, 32'h1);
    check("t4_addr", imem_addr, 32'h200);
    dec_ready = 1'b1;
    wait_dec("t4_dec", 20);
    check("t4_pc", dec_pc, 32'h200);

    // Misaligned redirect halts; aligned redirect resumes
    pulse_redirect(32'h102);
    check("t5_mis", {31'b0, fetch_misaligned}, 32'h1);
    req_cnt = 0;
    dec_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) req_cnt++;
      if (dec_en)   dec_cnt++;
      tick();
    end
    check("t5_no_req", req_cnt, 0);
    check("t5_no_dec", dec_cnt, 0);
    check("t5_addr_lsb", {30'b0, imem_addr[1:0]}, 32'h0);
    pulse_redirect(32'h300);
    wait_req_addr("t5_resume", 32'h300, 20);
    check("t5_mis_sticky", {31'b0, fetch_misaligned}, 32'h1);
    wait_dec("t5_dec", 20);
    check("t5_pc", dec_pc, 32'h300);

    // PC wrap at the top of the address space
    pulse_redirect(32'hFFFF_FFFC);
    wait_req_addr("t6_req_top", 32'hFFFF_FFFC, 20);
    wait_dec("t6_dec", 20);
    check("t6_pc",   dec_pc, 32'hFFFF_FFFC);
    check("t6_code", dec_instruction_code, mem_word(32'hFFFF_FFFC));
    wait_req_addr("t6_wrap", 32'h0, 20);

    // Reset pulse while a slow response is outstanding
    mem_lat = 3;
    tick();
    rst    = 1'b1;
    gnt_en = 0;
    tick();
    check("t7_req",  {31'b0, imem_req}, 32'h0);
    check("t7_addr", imem_addr, 32'h0);
    check("t7_dec_en", {31'b0, dec_en}, 32'h0);
    check("t7_code", dec_instruction_code, 32'h0);
    check("t7_pc",   dec_pc, 32'h0);
    check("t7_mis",  {31'b0, fetch_misaligned}, 32'h0);
    rst = 1'b0;
    dec_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dec_en) dec_cnt++;
    end
    check("t7_late_ignored", dec_cnt, 0);
    check("t7_req_held",  {31'b0, imem_req}, 32'h1);
    check("t7_addr_held", imem_addr, 32'h0);
    gnt_en = 1;
    wait_dec("t7_dec", 20);
    check("t7_first_pc",   dec_pc, 32'h0);
    check("t7_first_code", dec_instruction_code, 32'h0050_0093);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
